// File: rtl/uart_tx_sched.sv
// uart_tx_sched: boot-time SPBRG/TXSTA configurator plus round-robin TXREG
// scheduler for two byte requesters (A, B), paced on the UART's TXIF.
// Ports: clk, rst (async, active-low); a_valid/a_data/a_ready and
// b_valid/b_data/b_ready requester handshakes; uart_txif, uart_trmt from
// the UART; uart_reg_data plus SPBRG/TXSTA/TXREG write strobes to the UART;
// sched_idle status; last_grant (0 = A, 1 = B).
// Optional feature macro: UART_TX_SCHED_NINEBIT_EN (9-bit data, TX9D load).
module uart_tx_sched #(
    parameter logic [7:0] BAUD_DIV = 8'd25,
    parameter logic       BRGH     = 1'b1,
`ifdef UART_TX_SCHED_NINEBIT_EN
    localparam int        DW       = 9,
    localparam logic      TX9      = 1'b1
`else
    localparam int        DW       = 8,
    localparam logic      TX9      = 1'b0
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    input  logic          uart_txif,
    input  logic          uart_trmt,
    output logic [7:0]    uart_reg_data,
    output logic          uart_spbrg_wr_en,
    output logic          uart_txsta_wr_en,
    output logic          uart_txreg_wr_en,
    output logic          sched_idle,
    output logic          last_grant
);

    typedef enum logic [2:0] {
        CFG_BRG,
        CFG_STA,
        ARB,
        STA9,
        WR,
        DRAIN
    } state_t;

    state_t        state, state_n;
    logic [1:0]    cnt, cnt_n;
    logic [DW-1:0] byte_q, byte_n;
    logic          grant_n;
    logic          win_b;
    logic [7:0]    reg_data_n;
    logic          spbrg_n, txsta_n, txreg_n;
    logic          a_ready_n, b_ready_n;

    // TXSTA image: CSRC=0, TX9, TXEN=1, SYNC=0, -, BRGH, TRMT(ro)=0, TX9D
    function automatic logic [7:0] sta_byte(input logic tx9d);
        return {1'b0, TX9, 1'b1, 1'b0, 1'b0, BRGH, 1'b0, tx9d};
    endfunction

    assign sched_idle = (state == ARB) && !a_valid && !b_valid
                        && uart_txif && uart_trmt;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        byte_n     = byte_q;
        grant_n    = last_grant;
        reg_data_n = uart_reg_data;
        spbrg_n    = 1'b0;
        txsta_n    = 1'b0;
        txreg_n    = 1'b0;
        a_ready_n  = 1'b0;
        b_ready_n  = 1'b0;
        // On a tie the requester not served last wins
        win_b      = (a_valid && b_valid) ? !last_grant : b_valid;
        unique case (state)
            CFG_BRG: begin
                spbrg_n    = 1'b1;
                reg_data_n = BAUD_DIV;
                state_n    = CFG_STA;
            end
            CFG_STA: begin
                txsta_n    = 1'b1;
                reg_data_n = sta_byte(1'b0);
                state_n    = ARB;
            end
            ARB: begin
                if (uart_txif && (a_valid || b_valid)) begin
                    grant_n = win_b;
                    byte_n  = win_b ? b_data : a_data;
`ifdef UART_TX_SCHED_NINEBIT_EN
                    state_n = STA9;
`else
                    state_n = WR;
`endif
                end
            end
`ifdef UART_TX_SCHED_NINEBIT_EN
            STA9: begin
                txsta_n    = 1'b1;
                reg_data_n = sta_byte(byte_q[8]);
                state_n    = WR;
            end
`endif
            WR: begin
                txreg_n    = 1'b1;
                reg_data_n = byte_q[7:0];
                a_ready_n  = !last_grant;
                b_ready_n  = last_grant;
                cnt_n      = 2'd2;
                state_n    = DRAIN;
            end
            DRAIN: begin
                if (cnt != 2'd0)
                    cnt_n = cnt - 2'd1;
                // TXIF is only trusted once the blank has run out
                if (cnt_n == 2'd0 && uart_txif)
                    state_n = ARB;
            end
            default: state_n = CFG_BRG;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= CFG_BRG;
            cnt              <= 2'd0;
            byte_q           <= '0;
            last_grant       <= 1'b1;
            uart_reg_data    <= 8'h00;
            uart_spbrg_wr_en <= 1'b0;
            uart_txsta_wr_en <= 1'b0;
            uart_txreg_wr_en <= 1'b0;
            a_ready          <= 1'b0;
            b_ready          <= 1'b0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            byte_q           <= byte_n;
            last_grant       <= grant_n;
            uart_reg_data    <= reg_data_n;
            uart_spbrg_wr_en <= spbrg_n;
            uart_txsta_wr_en <= txsta_n;
            uart_txreg_wr_en <= txreg_n;
            a_ready          <= a_ready_n;
            b_ready          <= b_ready_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scenario tasks against uart_tx_sched with a small
// UART TXIF/TRMT model and a scoreboard of expected TXREG writes.
module tb_uart_tx_sched;

`ifdef UART_TX_SCHED_NINEBIT_EN
    localparam int DW = 9;
    localparam logic [7:0] STA_BOOT = 8'h64;
`else
    localparam int DW = 8;
    localparam logic [7:0] STA_BOOT = 8'h24;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a_valid = 1'b0;
    logic [DW-1:0] a_data = '0;
    logic          a_ready;
    logic          b_valid = 1'b0;
    logic [DW-1:0] b_data = '0;
    logic          b_ready;
    logic          uart_txif;
    logic          uart_trmt;
    logic [7:0]    uart_reg_data;
    logic          uart_spbrg_wr_en;
    logic          uart_txsta_wr_en;
    logic          uart_txreg_wr_en;
    logic          sched_idle;
    logic          last_grant;

    int passed = 0;
    int total  = 0;

    // scoreboard entry: {grant, byte}
    logic [8:0] sb[$];
    logic [8:0] exp_e;

    // UART model: TXREG busy for frame_len cycles after each write
    int   frame_len = 6;
    int   busy = 0;
    logic txif_hold = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (uart_txreg_wr_en) busy <= frame_len;
        else if (busy != 0) busy <= busy - 1;
    end

    assign uart_txif = (busy == 0) && !txif_hold;
    assign uart_trmt = (busy == 0);

    uart_tx_sched dut (
        .clk              (clk),
        .rst              (rst),
        .a_valid          (a_valid),
        .a_data           (a_data),
        .a_ready          (a_ready),
        .b_valid          (b_valid),
        .b_data           (b_data),
        .b_ready          (b_ready),
        .uart_txif        (uart_txif),
        .uart_trmt        (uart_trmt),
        .uart_reg_data    (uart_reg_data),
        .uart_spbrg_wr_en (uart_spbrg_wr_en),
        .uart_txsta_wr_en (uart_txsta_wr_en),
        .uart_txreg_wr_en (uart_txreg_wr_en),
        .sched_idle       (sched_idle),
        .last_grant       (last_grant)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!sched_idle && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (!sched_idle)
            $display("FAIL wait_idle: sched_idle=%b required 1", sched_idle);
        else
            passed++;
    endtask

    task automatic test_reset();
        logic [13:0] got;
        repeat (2) tick();
        got = {uart_spbrg_wr_en, uart_txsta_wr_en, uart_txreg_wr_en,
               a_ready, b_ready, uart_reg_data, last_grant};
        total++;
        if (got !== 14'b00000_00000000_1)
            $display("FAIL reset_vals: got %b required %b", got,
                     14'b00000_00000000_1);
        else passed++;
        rst = 1'b1;
        tick();
        total++;
        if ({uart_spbrg_wr_en, uart_txsta_wr_en, uart_reg_data}
            !== {2'b10, 8'h19})
            $display("FAIL boot_c1: spbrg=%b txsta=%b data=%h required 1 0 19",
                     uart_spbrg_wr_en, uart_txsta_wr_en, uart_reg_data);
        else passed++;
        tick();
        total++;
        if ({uart_spbrg_wr_en, uart_txsta_wr_en, uart_reg_data}
            !== {2'b01, STA_BOOT})
            $display("FAIL boot_c2: spbrg=%b txsta=%b data=%h required 0 1 %h",
                     uart_spbrg_wr_en, uart_txsta_wr_en, uart_reg_data, STA_BOOT);
        else passed++;
        tick();
        total++;
        if ({sched_idle, uart_txsta_wr_en, uart_txreg_wr_en} !== 3'b100)
            $display("FAIL boot_c3: idle=%b txsta=%b txreg=%b required 1 0 0",
                     sched_idle, uart_txsta_wr_en, uart_txreg_wr_en);
        else passed++;
    endtask

    task automatic test_single();
        int viol, n;
        a_valid = 1'b1;
        a_data  = 'h55;
        sb.push_back({1'b0, 8'h55});
`ifdef UART_TX_SCHED_NINEBIT_EN
        tick();
`endif
        tick();
        total++;
        if (uart_txreg_wr_en !== 1'b0)
            $display("FAIL single_early: txreg=%b required 0", uart_txreg_wr_en);
        else passed++;
        tick();
        exp_e = sb.pop_front();
        total++;
        if ({uart_txreg_wr_en, uart_reg_data, a_ready, b_ready, last_grant}
            !== {1'b1, exp_e[7:0], 1'b1, 1'b0, exp_e[8]})
            $display("FAIL single_wr: wr=%b data=%h ar=%b br=%b lg=%b required 1 %h 1 0 %b",
                     uart_txreg_wr_en, uart_reg_data, a_ready, b_ready,
                     last_grant, exp_e[7:0], exp_e[8]);
        else passed++;
        // A offers a second byte immediately; it must wait for TXIF
        a_data = 'h56;
        sb.push_back({1'b0, 8'h56});
        viol = 0;
        n = 0;
        tick();
        while (!uart_txif && n < 60) begin
            if (uart_txreg_wr_en) viol++;
            tick();
            n++;
        end
        total++;
        if (viol != 0 || !uart_txif)
            $display("FAIL single_pace: early writes=%0d txif=%b required 0 1",
                     viol, uart_txif);
        else passed++;
        n = 0;
        while (!uart_txreg_wr_en && n < 20) begin
            tick();
            n++;
        end
        exp_e = sb.pop_front();
        total++;
        if ({uart_txreg_wr_en, uart_reg_data, a_ready}
            !== {1'b1, exp_e[7:0], 1'b1})
            $display("FAIL single_second: wr=%b data=%h ar=%b required 1 %h 1",
                     uart_txreg_wr_en, uart_reg_data, a_ready, exp_e[7:0]);
        else passed++;
        a_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n, t0, t1;
        wait_idle();
        frame_len = 0;
        a_valid = 1'b1;
        a_data  = 'h3C;
        sb.push_back({1'b0, 8'h3C});
        sb.push_back({1'b0, 8'h3C});
        t0 = 0;
        t1 = 0;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            tick();
            while (!uart_txreg_wr_en && n < 40) begin
                tick();
                n++;
            end
            if (k == 0) t0 = cyc;
            else t1 = cyc;
            exp_e = sb.pop_front();
            total++;
            if ({uart_txreg_wr_en, uart_reg_data, a_ready}
                !== {1'b1, exp_e[7:0], 1'b1})
                $display("FAIL b2b_wr%0d: wr=%b data=%h ar=%b required 1 %h 1",
                         k, uart_txreg_wr_en, uart_reg_data, a_ready, exp_e[7:0]);
            else passed++;
        end
        a_valid = 1'b0;
        total++;
`ifdef UART_TX_SCHED_NINEBIT_EN
        if (t1 - t0 != 5)
            $display("FAIL b2b_spacing: got %0d required 5", t1 - t0);
`else
        if (t1 - t0 != 4)
            $display("FAIL b2b_spacing: got %0d required 4", t1 - t0);
`endif
        else passed++;
        frame_len = 6;
    endtask

    task automatic test_backpressure();
        int viol;
        wait_idle();
        txif_hold = 1'b1;
        b_valid = 1'b1;
        b_data  = 'h7E;
        sb.push_back({1'b1, 8'h7E});
        viol = 0;
        repeat (50) begin
            tick();
            if (uart_spbrg_wr_en || uart_txsta_wr_en || uart_txreg_wr_en
                || b_ready || a_ready) viol++;
        end
        total++;
        if (viol != 0)
            $display("FAIL bp_hold: active cycles=%0d required 0", viol);
        else passed++;
        txif_hold = 1'b0;
        tick();
`ifdef UART_TX_SCHED_NINEBIT_EN
        tick();
`endif
        total++;
        if (uart_txreg_wr_en !== 1'b0)
            $display("FAIL bp_early: txreg=%b required 0", uart_txreg_wr_en);
        else passed++;
        tick();
        exp_e = sb.pop_front();
        total++;
        if ({uart_txreg_wr_en, uart_reg_data, b_ready, a_ready, last_grant}
            !== {1'b1, exp_e[7:0], 1'b1, 1'b0, exp_e[8]})
            $display("FAIL bp_wr: wr=%b data=%h br=%b ar=%b lg=%b required 1 %h 1 0 1",
                     uart_txreg_wr_en, uart_reg_data, b_ready, a_ready,
                     last_grant, exp_e[7:0]);
        else passed++;
        b_valid = 1'b0;
    endtask

    task automatic test_round_robin();
        int n;
        wait_idle();
        a_valid = 1'b1;
        a_data  = 'hA1;
        b_valid = 1'b1;
        b_data  = 'hB2;
        sb.push_back({1'b0, 8'hA1});
        sb.push_back({1'b1, 8'hB2});
        sb.push_back({1'b0, 8'hA1});
        sb.push_back({1'b1, 8'hB2});
        for (int k = 0; k < 4; k++) begin
            n = 0;
            tick();
            while (!uart_txreg_wr_en && n < 60) begin
                tick();
                n++;
            end
            exp_e = sb.pop_front();
            total++;
            if ({uart_txreg_wr_en, uart_reg_data, last_grant, a_ready, b_ready}
                !== {1'b1, exp_e[7:0], exp_e[8], !exp_e[8], exp_e[8]})
                $display("FAIL rr_%0d: wr=%b data=%h lg=%b ar=%b br=%b required 1 %h %b",
                         k, uart_txreg_wr_en, uart_reg_data, last_grant,
                         a_ready, b_ready, exp_e[7:0], exp_e[8]);
            else passed++;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        wait_idle();
        a_valid = 1'b1;
        a_data  = 'h99;
        n = 0;
        tick();
        while (!uart_txreg_wr_en && n < 40) begin
            tick();
            n++;
        end
        tick();
        rst = 1'b0;
        #1;
        total++;
        if ({uart_spbrg_wr_en, uart_txsta_wr_en, uart_txreg_wr_en,
             a_ready, uart_reg_data, last_grant} !== {4'b0000, 8'h00, 1'b1})
            $display("FAIL mid_rst: sp=%b sta=%b tx=%b ar=%b data=%h lg=%b required 0 0 0 0 00 1",
                     uart_spbrg_wr_en, uart_txsta_wr_en, uart_txreg_wr_en,
                     a_ready, uart_reg_data, last_grant);
        else passed++;
        repeat (8) tick();
        sb.push_back({1'b0, 8'h99});
        rst = 1'b1;
        tick();
        total++;
        if ({uart_spbrg_wr_en, uart_txsta_wr_en, uart_txreg_wr_en,
             uart_reg_data} !== {3'b100, 8'h19})
            $display("FAIL mid_c1: sp=%b sta=%b tx=%b data=%h required 1 0 0 19",
                     uart_spbrg_wr_en, uart_txsta_wr_en, uart_txreg_wr_en,
                     uart_reg_data);
        else passed++;
        tick();
        total++;
        if ({uart_spbrg_wr_en, uart_txsta_wr_en, uart_txreg_wr_en,
             uart_reg_data} !== {3'b010, STA_BOOT})
            $display("FAIL mid_c2: sp=%b sta=%b tx=%b data=%h required 0 1 0 %h",
                     uart_spbrg_wr_en, uart_txsta_wr_en, uart_txreg_wr_en,
                     uart_reg_data, STA_BOOT);
        else passed++;
        tick();
`ifdef UART_TX_SCHED_NINEBIT_EN
        tick();
`endif
        total++;
        if (uart_txreg_wr_en !== 1'b0)
            $display("FAIL mid_c3: txreg=%b required 0", uart_txreg_wr_en);
        else passed++;
        tick();
        exp_e = sb.pop_front();
        total++;
        if ({uart_txreg_wr_en, uart_reg_data, a_ready, last_grant}
            !== {1'b1, exp_e[7:0], 1'b1, exp_e[8]})
            $display("FAIL mid_wr: wr=%b data=%h ar=%b lg=%b required 1 %h 1 0",
                     uart_txreg_wr_en, uart_reg_data, a_ready, last_grant,
                     exp_e[7:0]);
        else passed++;
        a_valid = 1'b0;
    endtask

`ifdef UART_TX_SCHED_NINEBIT_EN
    task automatic test_ninebit();
        wait_idle();
        b_valid = 1'b1;
        b_data  = 9'h1C3;
        sb.push_back({1'b1, 8'hC3});
        tick();
        tick();
        total++;
        if ({uart_txsta_wr_en, uart_txreg_wr_en, uart_reg_data}
            !== {2'b10, 8'h65})
            $display("FAIL nine_sta: sta=%b tx=%b data=%h required 1 0 65",
                     uart_txsta_wr_en, uart_txreg_wr_en, uart_reg_data);
        else passed++;
        tick();
        exp_e = sb.pop_front();
        total++;
        if ({uart_txreg_wr_en, uart_reg_data, b_ready}
            !== {1'b1, exp_e[7:0], 1'b1})
            $display("FAIL nine_wr: wr=%b data=%h br=%b required 1 %h 1",
                     uart_txreg_wr_en, uart_reg_data, b_ready, exp_e[7:0]);
        else passed++;
        b_valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_round_robin();
        test_reset_mid();
`ifdef UART_TX_SCHED_NINEBIT_EN
        test_ninebit();
`endif
        total++;
        if (sb.size() != 0)
            $display("FAIL sb_empty: left=%0d required 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler and boot-time configurator for the asynchronous `uart` peripheral.
- After reset it programs SPBRG and TXSTA through the UART's register write strobes.
- It then shares TXREG between two byte requesters, A (CPU mailbox) and B (debug/trace), using round-robin arbitration.
- It paces TXREG writes on the UART's `txif_set_en` strobe, so no byte is overwritten before the TSR consumes it.

## Interface
Parameters:
- `BAUD_DIV`, 8'd25: value written to SPBRG at boot.
- `BRGH`, 1'b1: high-speed baud select written to TXSTA[2].

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-low.
- `a_valid` input 1: requester A has a byte.
- `a_data` input 8 (9 with `UART_TX_SCHED_NINEBIT_EN`): requester A byte; bit 8 is TX9D.
- `a_ready` output 1: one-cycle accept pulse to A.
- `b_valid` input 1: requester B has a byte.
- `b_data` input 8 (9 with `UART_TX_SCHED_NINEBIT_EN`): requester B byte.
- `b_ready` output 1: one-cycle accept pulse to B.
- `uart_txif` input 1: the UART's `txif_set_en`; 1 means TXREG is free.
- `uart_trmt` input 1: TXSTA[1]; 1 means the TSR is empty.
- `uart_reg_data` output 8: drives the UART `reg_data_in`.
- `uart_spbrg_wr_en` output 1: SPBRG write strobe.
- `uart_txsta_wr_en` output 1: TXSTA write strobe.
- `uart_txreg_wr_en` output 1: TXREG write strobe.
- `sched_idle` output 1: high when the scheduler is in ARB, no valid is pending, and `uart_txif` and `uart_trmt` are both 1.
- `last_grant` output 1: 0 = A, 1 = B; the requester most recently served.

## Operation
- All outputs are registered, except `sched_idle`, which is combinational from state and inputs.
- Reset values: all strobes 0, `a_ready` 0, `b_ready` 0, `uart_reg_data` 8'h00, `last_grant` 1 (so A wins the first tie), state CFG_BRG.
- States:
  - CFG_BRG → CFG_STA: drives `uart_spbrg_wr_en`=1 with data=`BAUD_DIV`.
  - CFG_STA → ARB: drives `uart_txsta_wr_en`=1 with data={0,TX9,1,0,0,BRGH,0,0}. TXEN=1; TX9=1 only with the macro. Default data 8'h24.
  - ARB: holds while `uart_txif`=0 or no valid is asserted.
    - Otherwise it picks the winner: the single valid requester, or on a tie the requester ≠ `last_grant`.
    - It latches the winner's data, updates `last_grant`, and goes to WR (or to STA9 with the macro).
  - STA9 (macro only) → WR: writes TXSTA with TX9D = winner bit 8, other fields as in CFG_STA.
  - WR → DRAIN: `uart_txreg_wr_en`=1 with data = latched byte[7:0]; the winner's `*_ready` pulses in this same cycle.
  - DRAIN → ARB: a 2-bit blanking counter, loaded with 2 on entry, must reach 0, and then `uart_txif` must equal 1.
- Handshake:
  - A requester holds `*_valid` and `*_data` stable until it sees `*_ready`=1.
  - The transfer completes on the cycle where valid and ready are both 1.
  - Ready is never asserted without valid having been high at the decision edge.
- Blanking: `uart_txif` is stale for 1 cycle after a TXREG write, so it is ignored during the blank.
- Deassertion of a pending valid before ready is a protocol violation; it is not checked and the latched byte is still sent.
- Reset assertion mid-operation immediately forces the reset values and restarts at CFG_BRG. A byte already in TXREG or the TSR is the UART's concern.

## Timing
- Boot: the first rising edge after `rst` deasserts enters the CFG_BRG output cycle. The SPBRG strobe is at cycle 1, the TXSTA strobe at cycle 2, and ARB is reached at cycle 3.
- Accept latency:
  - Without the macro: valid seen in ARB at edge t gives `txreg_wr_en` and ready at t+1.
  - With the macro: t+2, with the TXSTA strobe at t+1.
- Minimum spacing between TXREG writes is 4 cycles (WR + 2 blank + ARB), or 5 with the macro. Actual spacing is governed by `uart_txif`.
- Round-robin fairness: with both requesters continuously valid, grants strictly alternate. No requester waits more than one other frame.

## Configuration
- Macro `UART_TX_SCHED_NINEBIT_EN`.
- Defined:
  - Requester data widens to 9 bits.
  - CFG_STA sets TX9=1.
  - STA9 is inserted before every WR to load TX9D.
- Undefined:
  - 8-bit data, TX9=0.
  - STA9 is absent and is never entered.
  - TX9D is always written 0.

## Test plan
- Boot: release `rst` with defaults → cycle 1 SPBRG strobe data 8'h19; cycle 2 TXSTA strobe data 8'h24; cycle 3 `sched_idle`=1 with TXIF=TRMT=1.
- Single byte: `a_valid`=1, `a_data`=8'h55, TXIF=1 → next cycle `uart_txreg_wr_en`=1, data 8'h55, `a_ready`=1; no further write until TXIF returns 1.
- Round-robin: A and B both continuously valid (8'hA1/8'hB2), model UART TXIF → TXREG sequence A1, B2, A1, B2; `last_grant` toggles 0, 1, 0, 1.
- Backpressure: hold `uart_txif`=0 for 50 cycles with B valid → no strobes, `b_ready`=0 throughout; TXIF rises → write one cycle later.
- Reset mid-DRAIN: assert `rst` low during the blank → strobes 0 immediately; on release the SPBRG then TXSTA sequence repeats before any new TXREG write.
- Macro defined: `b_data`=9'h1C3 → TXSTA strobe data 8'h65, next cycle TXREG strobe data 8'hC3 with `b_ready`=1.
